// File: rtl/conv_mesh_rc.sv
// conv_mesh_rc: output-stationary ROWS x COLS signed multiply-accumulate mesh.
//
// A tile starts with start/len while the mesh is idle. The mesh then takes
// len kIn/nIn beats under an in_valid/in_ready handshake, and each beat adds
// kIn[i]*nIn[j] into cell (i,j). The mesh then drains one accumulator row per
// out_valid/out_ready handshake, and pulses done after the last row.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   start, len          tile start (idle only) and beat count (0 = drain zeros)
//   busy                high whenever the mesh is not idle
//   in_valid, in_ready  input beat handshake; kIn (ROWS lanes), nIn (COLS lanes)
//   out_valid, out_ready, out_data, out_row   row drain handshake
//   done                one-cycle pulse after the final row handshake
//
// Build option: define CONV_MESH_SAT_EN so that each accumulator update
// saturates to the signed ACC_W range. Without it, updates wrap in two's
// complement.
module conv_mesh_rc #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int W     = 16,
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic                                     CLK,
    input  logic                                     RST,
    input  logic                                     start,
    input  logic [LEN_W-1:0]                         len,
    output logic                                     busy,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [W*ROWS-1:0]                        kIn,
    input  logic [W*COLS-1:0]                        nIn,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [ACC_W*COLS-1:0]                    out_data,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
    output logic                                     done
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t                   state, state_nx;
    logic [LEN_W-1:0]         cnt;
    logic [RW-1:0]            row;
    logic signed [ACC_W-1:0]  acc [ROWS][COLS];
    logic                     beat, hs, last_row;

    // One cell update: a full-precision signed product, sign-extended to the
    // accumulator width and then added. The add wraps or clamps, depending on
    // the build option.
    function automatic logic signed [ACC_W-1:0] mac(
        input logic signed [ACC_W-1:0] a,
        input logic signed [W-1:0]     k,
        input logic signed [W-1:0]     n
    );
        logic signed [2*W-1:0]   p;
        logic signed [ACC_W-1:0] pe;
        p  = k * n;
        pe = ACC_W'(p);
`ifdef CONV_MESH_SAT_EN
        begin
            logic signed [ACC_W:0] s;
            s = (ACC_W+1)'(a) + (ACC_W+1)'(pe);
            // The two top bits differ only when the ACC_W-bit result overflowed.
            if (s[ACC_W] != s[ACC_W-1])
                return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            return s[ACC_W-1:0];
        end
`else
        return a + pe;
`endif
    endfunction

    assign beat     = in_valid && in_ready;
    assign hs       = out_valid && out_ready;
    assign last_row = (row == RW'(ROWS - 1));

    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        in_ready  = (state == ACCUM);
        out_valid = (state == DRAIN);
        case (state)
            IDLE:    if (start) state_nx = (len == '0) ? DRAIN : ACCUM;
            ACCUM:   if (beat && cnt == LEN_W'(1)) state_nx = DRAIN;
            DRAIN:   if (hs && last_row) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt  <= '0;
            row  <= '0;
            done <= 1'b0;
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    acc[i][j] <= '0;
        end else begin
            done <= hs && last_row;
            if (state == IDLE && start) begin
                cnt <= len;
                row <= '0;
                for (int i = 0; i < ROWS; i++)
                    for (int j = 0; j < COLS; j++)
                        acc[i][j] <= '0;
            end else if (beat) begin
                cnt <= cnt - LEN_W'(1);
                for (int i = 0; i < ROWS; i++)
                    for (int j = 0; j < COLS; j++)
                        acc[i][j] <= mac(acc[i][j], $signed(kIn[W*i +: W]),
                                         $signed(nIn[W*j +: W]));
            end else if (hs) begin
                row <= last_row ? '0 : row + RW'(1);
            end
        end
    end

    // Drain output is a plain mux of the selected row, so it holds while stalled.
    always_comb begin
        out_data = '0;
        for (int j = 0; j < COLS; j++)
            out_data[ACC_W*j +: ACC_W] = acc[row][j];
    end

    assign out_row = row;

endmodule
